axi_mst_rd: RTL and testbench

//  AXI read-channel initiator; partner of axi_slv on the AR/R channels.
//  - Takes one burst command at a time from a local user port.
//  - Issues it on AR and collects the R beats.
//  - Forwards the beats, in order, to the user through a 2-entry buffer.
//  - Checks RLAST and RRESP, watches for a stalled slave, and reports a per-burst status pulse.
//  - One transaction outstanding; no RID on R, matching axi_slv.

---
 rtl/axi_mst_rd_pkg.sv | 35 +++
 rtl/axi_rd_skid_buf.sv | 48 ++++
 rtl/axi_mst_rd.sv | 166 ++++++++++++++++
 tb/tb_axi_mst_rd.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mst_rd_pkg.sv
// Shared AXI widths, encodings, FSM state codes and the buffered beat layout
// for the AXI read-channel initiator.
package axi_mst_rd_pkg;

  localparam int AXI_ID_WIDTH    = 4;
  localparam int AXI_ADDR_WIDTH  = 32;
  localparam int AXI_LEN_WIDTH   = 8;
  localparam int AXI_SIZE_WIDTH  = 3;
  localparam int AXI_BURST_WIDTH = 2;
  localparam int AXI_DATA_WIDTH  = 32;
  localparam int AXI_RESP_WIDTH  = 2;

  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AR    = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_RESP_WIDTH-1:0] resp;
    logic                      last;
  } rd_beat_t;

endpackage

// File: rtl/axi_rd_skid_buf.sv
// Two-entry registered FIFO between the R channel and the user beat port.
// Push and pop may coincide at any occupancy; the producer never pushes when full.
module axi_rd_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_valid,
  output logic         o_full
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;

  assign o_dout  = r_mem[r_rptr];
  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi_mst_rd.sv
// AXI read-channel initiator: one burst outstanding, R beats forwarded in order
// through a 2-entry buffer, with RLAST/RRESP checking and an R-gap watchdog.
module axi_mst_rd
  import axi_mst_rd_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [AXI_ID_WIDTH-1:0]    i_cmd_id,
  input  logic [AXI_ADDR_WIDTH-1:0]  i_cmd_addr,
  input  logic [AXI_LEN_WIDTH-1:0]   i_cmd_len,
  input  logic [AXI_SIZE_WIDTH-1:0]  i_cmd_size,
  input  logic [AXI_BURST_WIDTH-1:0] i_cmd_burst,
  output logic [AXI_ID_WIDTH-1:0]    o_axi_mst_arid,
  output logic [AXI_ADDR_WIDTH-1:0]  o_axi_mst_araddr,
  output logic [AXI_LEN_WIDTH-1:0]   o_axi_mst_arlen,
  output logic [AXI_SIZE_WIDTH-1:0]  o_axi_mst_arsize,
  output logic [AXI_BURST_WIDTH-1:0] o_axi_mst_arburst,
  output logic                       o_axi_mst_arvalid,
  input  logic                       i_axi_mst_arready,
  input  logic [AXI_DATA_WIDTH-1:0]  i_axi_mst_rdata,
  input  logic [AXI_RESP_WIDTH-1:0]  i_axi_mst_rresp,
  input  logic                       i_axi_mst_rlast,
  input  logic                       i_axi_mst_rvalid,
  output logic                       o_axi_mst_rready,
  output logic [AXI_DATA_WIDTH-1:0]  o_usr_rdata,
  output logic [AXI_RESP_WIDTH-1:0]  o_usr_rresp,
  output logic                       o_usr_rlast,
  output logic                       o_usr_rvalid,
  input  logic                       i_usr_rready,
  output logic                       o_done_valid,
  output logic [2:0]                 o_done_err,
  output logic                       o_busy
);

  localparam logic [AXI_LEN_WIDTH:0] CNT_ONE = 1;
  localparam logic [TIMEOUT_W-1:0]   WD_ONE  = 1;

  rd_state_e               r_state, w_next;
  logic [AXI_LEN_WIDTH:0]  r_beat_cnt;
  logic [TIMEOUT_W-1:0]    r_wd;
  logic                    r_drop;
  logic                    r_err_to, r_err_last, r_err_resp;
  logic                    w_rhs, w_exp_last, w_wd_expire;
  logic                    w_push, w_pop, w_full;
  rd_beat_t                w_beat_in, w_beat_out;

  assign w_rhs       = i_axi_mst_rvalid & o_axi_mst_rready;
  assign w_exp_last  = (r_beat_cnt == {1'b0, o_axi_mst_arlen});
  assign w_wd_expire = &r_wd;
  // After a missing RLAST the rest of the burst is swallowed until the slave ends it.
  assign w_push      = w_rhs & ~r_drop;
  assign w_pop       = o_usr_rvalid & i_usr_rready;
  assign w_beat_in   = '{data: i_axi_mst_rdata, resp: i_axi_mst_rresp, last: i_axi_mst_rlast};

  axi_rd_skid_buf #(.W($bits(rd_beat_t))) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_beat_in),
    .i_pop   (w_pop),
    .o_dout  (w_beat_out),
    .o_valid (o_usr_rvalid),
    .o_full  (w_full)
  );

  assign o_usr_rdata = w_beat_out.data;
  assign o_usr_rresp = w_beat_out.resp;
  assign o_usr_rlast = w_beat_out.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    o_cmd_ready       = 1'b0;
    o_axi_mst_arvalid = 1'b0;
    o_axi_mst_rready  = 1'b0;
    o_done_valid      = 1'b0;
    o_done_err        = 3'b000;
    o_busy            = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_cmd_valid) w_next = ST_AR;
      end
      ST_AR: begin
        o_axi_mst_arvalid = 1'b1;
        if (i_axi_mst_arready) w_next = ST_RDATA;
      end
      ST_RDATA: begin
        o_axi_mst_rready = ~w_full & ~w_wd_expire;
        if (w_wd_expire)                         w_next = ST_DONE;
        else if (w_rhs && i_axi_mst_rlast)       w_next = ST_DONE;
      end
      ST_DONE: begin
        o_done_valid = 1'b1;
        o_done_err   = {r_err_to, r_err_last, r_err_resp};
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Watchdog only counts gaps the slave is responsible for, not buffer back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_axi_mst_arid    <= '0;
      o_axi_mst_araddr  <= '0;
      o_axi_mst_arlen   <= '0;
      o_axi_mst_arsize  <= '0;
      o_axi_mst_arburst <= '0;
      r_beat_cnt        <= '0;
      r_wd              <= '0;
      r_drop            <= 1'b0;
      r_err_to          <= 1'b0;
      r_err_last        <= 1'b0;
      r_err_resp        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            o_axi_mst_arid    <= i_cmd_id;
            o_axi_mst_araddr  <= i_cmd_addr;
            o_axi_mst_arlen   <= i_cmd_len;
            o_axi_mst_arsize  <= i_cmd_size;
            o_axi_mst_arburst <= i_cmd_burst;
            r_drop            <= 1'b0;
            r_err_to          <= 1'b0;
            r_err_last        <= 1'b0;
            r_err_resp        <= 1'b0;
          end
        end
        ST_AR: begin
          if (i_axi_mst_arready) begin
            r_beat_cnt <= '0;
            r_wd       <= '0;
          end
        end
        ST_RDATA: begin
          if (w_rhs) begin
            r_wd <= '0;
            if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + CNT_ONE;
            if (i_axi_mst_rresp != AXI_RESP_OKAY) r_err_resp <= 1'b1;
            if (!r_drop) begin
              if (i_axi_mst_rlast != w_exp_last) r_err_last <= 1'b1;
              if (!i_axi_mst_rlast && w_exp_last) r_drop <= 1'b1;
            end
          end else if (w_wd_expire) begin
            r_err_to <= 1'b1;
          end else if (!w_full) begin
            r_wd <= r_wd + WD_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mst_rd.sv
// Self-checking bench for axi_mst_rd: table of burst scenarios against a simple
// slave/consumer model, plus hand-written AR timing, watchdog and reset sequences.
module tb_axi_mst_rd;
  import axi_mst_rd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmdValid, cmdReady;
  logic [3:0]  cmdId;
  logic [31:0] cmdAddr;
  logic [7:0]  cmdLen;
  logic [2:0]  cmdSize;
  logic [1:0]  cmdBurst;
  logic [3:0]  arId;
  logic [31:0] arAddr;
  logic [7:0]  arLen;
  logic [2:0]  arSize;
  logic [1:0]  arBurst;
  logic        arValid, arReady;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rLast, rValid, rReady;
  logic [31:0] usrData;
  logic [1:0]  usrResp;
  logic        usrLast, usrValid, usrReady;
  logic        doneV;
  logic [2:0]  doneErr;
  logic        busy;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    int         len;
    int         nBeats;
    int         lastBeat;
    int         errBeat;
    bit         stall;
    int         expBeats;
    int         expLastIdx;
    logic [2:0] expErr;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  axi_mst_rd dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_cmd_valid       (cmdValid),
    .o_cmd_ready       (cmdReady),
    .i_cmd_id          (cmdId),
    .i_cmd_addr        (cmdAddr),
    .i_cmd_len         (cmdLen),
    .i_cmd_size        (cmdSize),
    .i_cmd_burst       (cmdBurst),
    .o_axi_mst_arid    (arId),
    .o_axi_mst_araddr  (arAddr),
    .o_axi_mst_arlen   (arLen),
    .o_axi_mst_arsize  (arSize),
    .o_axi_mst_arburst (arBurst),
    .o_axi_mst_arvalid (arValid),
    .i_axi_mst_arready (arReady),
    .i_axi_mst_rdata   (rData),
    .i_axi_mst_rresp   (rResp),
    .i_axi_mst_rlast   (rLast),
    .i_axi_mst_rvalid  (rValid),
    .o_axi_mst_rready  (rReady),
    .o_usr_rdata       (usrData),
    .o_usr_rresp       (usrResp),
    .o_usr_rlast       (usrLast),
    .o_usr_rvalid      (usrValid),
    .i_usr_rready      (usrReady),
    .o_done_valid      (doneV),
    .o_done_err        (doneErr),
    .o_busy            (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, cmdReady, 1);
    checkOutput({tag, "_arvalid"}, arValid, 0);
    checkOutput({tag, "_araddr"}, arAddr, 0);
    checkOutput({tag, "_arlen"}, arLen, 0);
    checkOutput({tag, "_rready"}, rReady, 0);
    checkOutput({tag, "_usr_rvalid"}, usrValid, 0);
    checkOutput({tag, "_done_valid"}, doneV, 0);
    checkOutput({tag, "_done_err"}, doneErr, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Returns at the falling edge right after the command handshake edge.
  task automatic sendCmd(input int len, input logic [31:0] addr);
    @(negedge clk);
    cmdValid = 1'b1;
    cmdId    = 4'h3;
    cmdAddr  = addr;
    cmdLen   = len[7:0];
    cmdSize  = 3'd2;
    cmdBurst = AXI_BURST_INCR;
    #1 checkOutput("cmd_ready_idle", cmdReady, 1);
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] base;
    int          guard, nGot, lastIdx, doneCnt, stallLeft;
    bit          hs, doneSeen, sawBp;
    logic [2:0]  err;
    base      = 32'hA000_0000 + 32'(idx) * 32'd256;
    nGot      = 0;
    lastIdx   = 15;
    doneCnt   = 0;
    doneSeen  = 1'b0;
    sawBp     = 1'b0;
    err       = 3'b000;
    stallLeft = v.stall ? 8 : 0;
    sendCmd(v.len, 32'h100 * 32'(idx));
    fork
      begin
        for (int b = 0; b < v.nBeats; b++) begin
          rValid = 1'b1;
          rData  = base + 32'(b);
          rResp  = (b == v.errBeat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          rLast  = (b == v.lastBeat);
          hs     = 1'b0;
          guard  = 0;
          while (!hs && guard < 100) begin
            #1 hs = rReady;
            @(posedge clk);
            @(negedge clk);
            guard++;
          end
          if (!hs) begin
            checkOutput($sformatf("v%0d_r_handshake_wait", idx), 0, 1);
            break;
          end
        end
        rValid = 1'b0;
        rLast  = 1'b0;
      end
      begin
        for (int c = 0; c < 400; c++) begin
          usrReady = !(v.stall && nGot >= 1 && stallLeft > 0);
          if (!usrReady) stallLeft--;
          #1;
          if (doneV) begin
            doneCnt++;
            err      = doneErr;
            doneSeen = 1'b1;
          end
          if (!usrReady && rValid && !rReady) sawBp = 1'b1;
          if (usrValid && usrReady) begin
            checkOutput($sformatf("v%0d_beat%0d_data", idx, nGot), usrData, base + 32'(nGot));
            checkOutput($sformatf("v%0d_beat%0d_resp", idx, nGot), usrResp,
                        (nGot == v.errBeat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
            if (usrLast && lastIdx == 15) lastIdx = nGot;
            nGot++;
          end
          if (doneSeen && !usrValid) break;
          @(negedge clk);
        end
      end
    join
    usrReady = 1'b1;
    checkOutput($sformatf("v%0d_beats", idx), nGot, v.expBeats);
    checkOutput($sformatf("v%0d_last_idx", idx), lastIdx, v.expLastIdx);
    checkOutput($sformatf("v%0d_done_pulses", idx), doneCnt, 1);
    checkOutput($sformatf("v%0d_done_err", idx), err, v.expErr);
    if (v.stall) checkOutput($sformatf("v%0d_backpressure", idx), sawBp, 1);
    @(negedge clk);
    #1 checkOutput($sformatf("v%0d_cmd_ready_after", idx), cmdReady, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int doneAt;
    logic [2:0] toErr;

    vecs[0] = '{len: 0, nBeats: 1, lastBeat: 0, errBeat: 99, stall: 0, expBeats: 1, expLastIdx: 0,  expErr: 3'b000};
    vecs[1] = '{len: 3, nBeats: 4, lastBeat: 3, errBeat: 99, stall: 1, expBeats: 4, expLastIdx: 3,  expErr: 3'b000};
    vecs[2] = '{len: 3, nBeats: 4, lastBeat: 3, errBeat: 1,  stall: 0, expBeats: 4, expLastIdx: 3,  expErr: 3'b001};
    vecs[3] = '{len: 3, nBeats: 1, lastBeat: 0, errBeat: 99, stall: 0, expBeats: 1, expLastIdx: 0,  expErr: 3'b010};
    vecs[4] = '{len: 3, nBeats: 6, lastBeat: 5, errBeat: 99, stall: 0, expBeats: 4, expLastIdx: 15, expErr: 3'b010};

    rst_n    = 1'b0;
    cmdValid = 1'b0;
    cmdId    = '0;
    cmdAddr  = '0;
    cmdLen   = '0;
    cmdSize  = '0;
    cmdBurst = '0;
    arReady  = 1'b1;
    rValid   = 1'b0;
    rData    = '0;
    rResp    = '0;
    rLast    = 1'b0;
    usrReady = 1'b1;
    repeat (3) @(negedge clk);
    #1 checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1 checkResetValues("post_reset");

    $display("[TB] AR timing and first-beat latency");
    sendCmd(0, 32'h10);
    #1;
    checkOutput("ar_valid_t1", arValid, 1);
    checkOutput("ar_addr", arAddr, 32'h10);
    checkOutput("ar_len", arLen, 0);
    checkOutput("ar_burst", arBurst, AXI_BURST_INCR);
    checkOutput("ar_id", arId, 4'h3);
    checkOutput("busy_in_ar", busy, 1);
    @(negedge clk);
    #1 checkOutput("ar_valid_one_cycle", arValid, 0);
    rValid = 1'b1;
    rData  = 32'hC0FF_EE00;
    rResp  = AXI_RESP_OKAY;
    rLast  = 1'b1;
    checkOutput("rready_in_rdata", rReady, 1);
    @(posedge clk);
    @(negedge clk);
    rValid = 1'b0;
    rLast  = 1'b0;
    #1;
    checkOutput("usr_rvalid_latency", usrValid, 1);
    checkOutput("usr_rdata_first", usrData, 32'hC0FF_EE00);
    checkOutput("usr_rlast_first", usrLast, 1);
    checkOutput("done_valid_first", doneV, 1);
    checkOutput("done_err_first", doneErr, 3'b000);
    @(negedge clk);
    #1;
    checkOutput("usr_rvalid_drained", usrValid, 0);
    checkOutput("done_valid_one_cycle", doneV, 0);
    checkOutput("cmd_ready_back", cmdReady, 1);

    $display("[TB] table-driven bursts");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    $display("[TB] watchdog");
    doneAt = 0;
    toErr  = 3'b000;
    sendCmd(1, 32'h200);
    for (int n = 1; n <= 400; n++) begin
      #1;
      if (n == 256) checkOutput("rready_before_timeout", rReady, 1);
      if (n == 257) checkOutput("rready_at_timeout", rReady, 0);
      if (doneV) begin
        doneAt = n;
        toErr  = doneErr;
        break;
      end
      @(negedge clk);
    end
    checkOutput("timeout_done_cycle", doneAt, 258);
    checkOutput("timeout_done_err", toErr, 3'b100);

    $display("[TB] reset mid-burst");
    usrReady = 1'b0;
    sendCmd(3, 32'h300);
    rValid = 1'b1;
    rData  = 32'h5555_0000;
    rResp  = AXI_RESP_OKAY;
    rLast  = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("buffer_holds_before_reset", usrValid, 1);
    checkOutput("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1 checkResetValues("mid_reset");
    rValid   = 1'b0;
    usrReady = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 checkResetValues("after_mid_reset");
    applyStimulus(vecs[0], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
